// File: rtl/wh_pkg.sv
// Shared defaults and state encoding for the wh bus initiator.
package wh_pkg;
    localparam int WH_AW          = 32;
    localparam int WH_DW          = 32;
    localparam int WH_MAX_BURST   = 16;
    localparam int WH_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {IDLE, WFETCH, BUS, DONE} wh_mst_state_e;
endpackage

// File: rtl/wh_beat_timer.sv
// Counts cycles a beat has waited for ack; expired is high in the last allowed cycle.
// Single-cycle combinational expiry from a registered count; no backpressure.
module wh_beat_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    // count is 0 in the first waiting cycle, so TIMEOUT_CYC-1 marks the final one
    assign expired = en && (count == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/wh_master_ctrl.sv
// wh bus initiator: queued read/write bursts to cyc/stb/ack cycles, per-beat ack timeout.
// Read beat: ack to rdat_valid 1 cycle; requests stall in non-IDLE states, write beats pulled on demand.
module wh_master_ctrl
    import wh_pkg::*;
#(
    parameter int AW          = WH_AW,
    parameter int DW          = WH_DW,
    parameter int MAX_BURST   = WH_MAX_BURST,
    parameter int TIMEOUT_CYC = WH_TIMEOUT_CYC
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [AW-1:0]                req_adr_i,
    input  logic [$clog2(MAX_BURST)-1:0] req_len_i,
    input  logic [DW-1:0]                wdat_i,
    input  logic                         wdat_valid_i,
    output logic                         wdat_ready_o,
    output logic [DW-1:0]                rdat_o,
    output logic                         rdat_valid_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         cyc_o,
    output logic                         stb_o,
    output logic                         we_o,
    output logic [AW-1:0]                adr_o,
    output logic [DW-1:0]                dat_o,
    output logic [DW/8-1:0]              sel_o,
    input  logic                         ack_i,
    input  logic [DW-1:0]                dat_i
);
    localparam int LW = $clog2(MAX_BURST);

    wh_mst_state_e state;
    logic [LW-1:0] beats_left;
    logic          expired;

    wh_beat_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clr     ((state != BUS) || ack_i),
        .en      (state == BUS),
        .expired (expired)
    );

    assign req_ready_o  = (state == IDLE);
    assign wdat_ready_o = (state == WFETCH);
    assign sel_o        = '1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            beats_left   <= '0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
            rdat_o       <= '0;
            rdat_valid_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdat_valid_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        cyc_o      <= 1'b1;
                        we_o       <= req_we_i;
                        adr_o      <= req_adr_i;
                        beats_left <= req_len_i;
                        if (req_we_i) begin
                            state <= WFETCH;
                        end else begin
                            stb_o <= 1'b1;
                            state <= BUS;
                        end
                    end
                end
                WFETCH: begin
                    if (wdat_valid_i) begin
                        dat_o <= wdat_i;
                        stb_o <= 1'b1;
                        state <= BUS;
                    end
                end
                BUS: begin
                    // an ack arriving in the expiry cycle still completes the beat
                    if (ack_i) begin
                        if (!we_o) begin
                            rdat_o       <= dat_i;
                            rdat_valid_o <= 1'b1;
                        end
                        if (beats_left == '0) begin
                            cyc_o  <= 1'b0;
                            stb_o  <= 1'b0;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            adr_o      <= adr_o + AW'(DW / 8);
                            beats_left <= beats_left - LW'(1);
                            if (we_o) begin
                                stb_o <= 1'b0;
                                state <= WFETCH;
                            end
                        end
                    end else if (expired) begin
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wh_master_ctrl.sv
// Scoreboard bench for wh_master_ctrl with a randomized responder and burst-level reference model.
module tb_wh_master_ctrl;
    localparam int TO = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we;
    logic        req_ready_o;
    logic [31:0] req_adr;
    logic [3:0]  req_len;
    logic [31:0] wdat;
    logic        wdat_valid;
    logic        wdat_ready_o;
    logic [31:0] rdat_o;
    logic        rdat_valid_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        ack_i;
    logic [31:0] dat_i;

    wh_master_ctrl dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_len_i(req_len),
        .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready_o),
        .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] adr; logic we; logic [31:0] dat;} beat_t;
    typedef struct {logic [31:0] dat; int dly;} wword_t;

    beat_t       exp_beat_q[$];
    logic [31:0] exp_rdat_q[$];
    logic        exp_err_q[$];
    wword_t      wq[$];
    logic [31:0] fixed_w[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          resp_wait = 0;

    function automatic logic [31:0] resp_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Responder: acks a beat once it has waited resp_wait cycles
    initial begin
        int   w;
        logic prev;
        w = 0; prev = 1'b0; ack_i = 1'b0; dat_i = '0;
        forever begin
            @(posedge clk); #2;
            if (!stb_o || !prev || ack_i) w = 0;
            else w++;
            prev  = stb_o;
            ack_i = stb_o && (w >= resp_wait);
            dat_i = ack_i ? resp_data(adr_o) : 32'h0;
        end
    end

    // Write-data feeder
    initial begin
        wword_t ww;
        bit     acc;
        wdat_valid = 1'b0; wdat = '0;
        forever begin
            @(posedge clk); #1;
            if (wq.size() > 0) begin
                ww = wq.pop_front();
                repeat (ww.dly) @(posedge clk);
                #1;
                wdat_valid = 1'b1;
                wdat       = ww.dat;
                acc = 1'b0;
                for (int k = 0; k < 5000 && !acc; k++) begin
                    @(negedge clk); acc = wdat_ready_o;
                    @(posedge clk); #1;
                end
                if (!acc) fail_now("wdat_accept_timeout");
                wdat_valid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (wdat_valid && wdat_ready_o) check("fetch_no_stb", {31'b0, stb_o}, 32'd0);
            if (stb_o && ack_i) begin
                if (exp_beat_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    b = exp_beat_q.pop_front();
                    check("beat_adr", adr_o, b.adr);
                    check("beat_we", {31'b0, we_o}, {31'b0, b.we});
                    if (b.we) check("beat_wdat", dat_o, b.dat);
                    check("beat_cyc", {31'b0, cyc_o}, 32'd1);
                end
            end
            if (rdat_valid_o) begin
                if (exp_rdat_q.size() == 0) fail_now("unexpected_rdat");
                else check("rdat", rdat_o, exp_rdat_q.pop_front());
            end
            if (done_o) begin
                if (exp_err_q.size() == 0) fail_now("unexpected_done");
                else begin
                    check("done_err", {31'b0, err_o}, {31'b0, exp_err_q.pop_front()});
                    check("done_cyc", {31'b0, cyc_o}, 32'd0);
                end
            end
        end
    end

    // Offers one burst and records its expected outcome.
    task automatic issue(input logic we, input logic [31:0] adr, input int len, input int wt,
                         input int first_dly, input int rest_dly);
        bit          acc, to;
        int          nb;
        logic [31:0] d, a;
        wword_t      ww;
        acc = 1'b0;
        for (int k = 0; k < 5000 && !acc; k++) begin @(negedge clk); acc = req_ready_o; end
        if (!acc) fail_now("idle_wait_timeout");
        @(posedge clk); #1;
        resp_wait = wt;
        to = (wt >= TO);
        nb = to ? 1 : len + 1;
        for (int i = 0; i < nb; i++) begin
            a = adr + 32'(4 * i);
            d = (fixed_w.size() > 0) ? fixed_w.pop_front() : $urandom();
            if (we) begin
                ww.dat = d;
                ww.dly = (i == 0) ? first_dly : ((rest_dly < 0) ? int'($urandom_range(0, 2)) : rest_dly);
                wq.push_back(ww);
            end
            if (!to) begin
                exp_beat_q.push_back('{adr: a, we: we, dat: d});
                if (!we) exp_rdat_q.push_back(resp_data(a));
            end
        end
        exp_err_q.push_back(to);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_len = 4'(len);
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk); acc = req_ready_o;
            @(posedge clk); #1;
        end
        if (!acc) fail_now("req_accept_timeout");
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready_o && exp_beat_q.size() == 0 && exp_rdat_q.size() == 0 &&
                 exp_err_q.size() == 0;
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    initial begin
        int cnt, r, wt;
        bit hit;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", {31'b0, cyc_o}, 32'd0);
        check("rst_stb", {31'b0, stb_o}, 32'd0);
        check("rst_we", {31'b0, we_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_rvld", {31'b0, rdat_valid_o}, 32'd0);
        check("rst_wrdy", {31'b0, wdat_ready_o}, 32'd0);
        check("rst_req_rdy", {31'b0, req_ready_o}, 32'd1);
        check("rst_adr", adr_o, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_rdat", rdat_o, 32'd0);
        check("sel_all_ones", {28'b0, sel_o}, 32'hF);
        @(posedge clk); #3; rst_n = 1'b1;

        // Single zero-wait read with latency profile
        issue(1'b0, 32'h100, 0, 0, 0, 0);
        @(negedge clk); check("lat_stb_t1", {31'b0, stb_o}, 32'd1);
        @(negedge clk); check("lat_done_t2", {31'b0, done_o}, 32'd1);
        check("lat_rvld_t2", {31'b0, rdat_valid_o}, 32'd1);
        check("lat_cyc_t2", {31'b0, cyc_o}, 32'd0);
        check("lat_rdy_t2", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk); check("lat_rdy_t3", {31'b0, req_ready_o}, 32'd1);
        drain();

        // 4-beat read, two wait cycles per beat, cyc held throughout
        issue(1'b0, 32'h200, 3, 2, 0, 0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done_o) break;
            check("cyc_held", {31'b0, cyc_o}, 32'd1);
        end
        drain();

        // 2-beat write with a slow first data word
        fixed_w.push_back(32'hA5A5A5A5);
        fixed_w.push_back(32'h5A5A5A5A);
        issue(1'b1, 32'h300, 1, 1, 5, 0);
        drain();

        // No ack: stb held exactly TO cycles then error
        issue(1'b0, 32'h500, 0, 1000, 0, 0);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (stb_o) cnt++;
            else break;
        end
        check("timeout_stb_cycles", 32'(cnt), 32'd64);
        drain();

        // Ack in the final allowed cycle succeeds
        issue(1'b0, 32'h600, 0, TO - 1, 0, 0);
        drain();

        // Address wrap
        issue(1'b0, 32'hFFFF_FFFC, 1, 0, 0, 0);
        drain();

        // Reset during the second beat of a 4-beat read
        issue(1'b0, 32'h400, 3, 2, 0, 0);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk); hit = stb_o && (adr_o == 32'h404);
        end
        if (!hit) fail_now("beat2_not_seen");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_cyc", {31'b0, cyc_o}, 32'd0);
        check("midrst_stb", {31'b0, stb_o}, 32'd0);
        exp_beat_q.delete(); exp_rdat_q.delete(); exp_err_q.delete();
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h800, 1, 1, 0, 0);
        drain();

        // Randomized bursts
        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) wt = TO + int'($urandom_range(0, 5));
            else if (r == 1) wt = TO - 1;
            else wt = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), {$urandom()} & 32'hFFFF_FFFC,
                  $urandom_range(0, 15), wt, $urandom_range(0, 3), -1);
        end
        drain();
        check("wq_empty", 32'(wq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
